// File: rtl/adc_pkg.sv
// Shared definitions for the flash-ADC conversion controller: FSM states and
// the code, result and bubble-counter widths.
package adc_pkg;

    localparam int CODE_W = 15;
    localparam int RES_W  = 4;
    localparam int BCNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_ACCUM,
        ST_HOLD
    } adc_state_t;

endpackage

// File: rtl/adc_therm_ones_count.sv
// Bubble-tolerant thermometer encoder: counts the ones in the comparator code
// and flags whether the code is a clean 2^n-1 pattern.
module adc_therm_ones_count
    import adc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [RES_W-1:0]  ones,
    output logic              therm_ok
);

    logic [CODE_W-1:0] code_inc;

    always_comb begin
        ones = '0;
        for (int i = 0; i < CODE_W; i++) begin
            ones = ones + RES_W'(code[i]);
        end
    end

    // A clean thermometer code has no carry overlap with itself plus one.
    assign code_inc = code + CODE_W'(1);
    assign therm_ok = ~|(code & code_inc);

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion controller for a 15-comparator flash ADC: settles, latches and
// averages 2^AVG_LOG2 samples per result, with bubble detection and counting.
module adc_conv_ctrl
    import adc_pkg::*;
#(
    parameter int SETTLE_CYC = 3,
    parameter int AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [CODE_W-1:0] ith,
    output logic              sample_en,
    output logic              comp_latch,
    output logic [RES_W-1:0]  data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              bubble_err,
    output logic [BCNT_W-1:0] bubble_cnt
);

    localparam int ACC_W = RES_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    adc_state_t        state;
    adc_state_t        state_next;
    logic              clr_acc;
    logic              handshake;
    logic [3:0]        settle_cnt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CODE_W-1:0] ith_q;
    logic [RES_W-1:0]  ones;
    logic              therm_ok;

    adc_therm_ones_count u_ones (
        .code     (ith_q),
        .ones     (ones),
        .therm_ok (therm_ok)
    );

    assign handshake  = data_valid && data_ready;
    assign acc_sum    = acc + ACC_W'(ones);
    assign sample_en  = (state == ST_SETTLE);
    assign comp_latch = (state == ST_CAPTURE);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_acc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    clr_acc    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (sample_cnt == LAST_SAMPLE) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (continuous) begin
                        state_next = ST_SETTLE;
                        clr_acc    = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Settle timer runs only while staying in SETTLE, so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE && state_next == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            acc        <= '0;
            ith_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            bubble_err <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            if (clr_acc) begin
                sample_cnt <= '0;
                acc        <= '0;
            end
            if (state == ST_CAPTURE) begin
                ith_q <= ith;
            end
            if (state == ST_ACCUM) begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + CNT_W'(1);
                if (!therm_ok) begin
                    bubble_err <= 1'b1;
                    if (bubble_cnt != '1) begin
                        bubble_cnt <= bubble_cnt + BCNT_W'(1);
                    end
                end
                if (state_next == ST_HOLD) begin
                    data_out <= RES_W'(acc_sum >> AVG_LOG2);
                end
            end
            // Valid rises one cycle into HOLD and drops on the handshake edge.
            data_valid <= (state == ST_HOLD) && (state_next == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed self-checking bench for adc_conv_ctrl with default parameters.
module tb_adc_conv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [14:0] ith;
    logic        sample_en;
    logic        comp_latch;
    logic [3:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        bubble_err;
    logic [7:0]  bubble_cnt;

    int          nChecks = 0;
    int          nErrors = 0;
    int          lat;
    int          latches;
    logic [14:0] ith_seq [0:3];

    adc_conv_ctrl #(
        .SETTLE_CYC (3),
        .AVG_LOG2   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .ith        (ith),
        .sample_en  (sample_en),
        .comp_latch (comp_latch),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .bubble_err (bubble_err),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic r);
        start      = s;
        continuous = c;
        data_ready = r;
    endtask

    task automatic setSeq(input logic [14:0] a, input logic [14:0] b,
                          input logic [14:0] c, input logic [14:0] d);
        ith_seq[0] = a;
        ith_seq[1] = b;
        ith_seq[2] = c;
        ith_seq[3] = d;
    endtask

    // Called at a falling edge; latency counts rising edges from the edge that
    // launches the conversion (start edge or previous handshake edge).
    task automatic runConversion(input bit doStart, input int clearContAt, output int latency);
        int idx = 0;
        latency = -1;
        if (doStart) start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                checkOutput("settle_entry", 32'(sample_en), 32'd1);
            end
            if (k == clearContAt) continuous = 1'b0;
            if (comp_latch) begin
                if (idx < 4) ith = ith_seq[idx];
                idx++;
            end
            if (data_valid) begin
                latency = k;
                break;
            end
        end
        checkOutput("latch_count", 32'(idx), 32'd4);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        ith = '0;
        setSeq('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_valid", 32'(data_valid), 32'd0);
        checkOutput("rst_sample_en", 32'(sample_en), 32'd0);
        checkOutput("rst_latch", 32'(comp_latch), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bubble_err", 32'(bubble_err), 32'd0);
        checkOutput("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single conversion, code 0x007F");
        ith = 15'h007F;
        setSeq(15'h007F, 15'h007F, 15'h007F, 15'h007F);
        runConversion(1'b1, -1, lat);
        checkOutput("basic_latency", 32'(lat), 32'd21);
        checkOutput("basic_data", 32'(data_out), 32'd7);
        checkOutput("basic_bubble", 32'(bubble_err), 32'd0);
        @(negedge clk);
        checkOutput("basic_idle", 32'(busy), 32'd0);
        checkOutput("basic_valid_drop", 32'(data_valid), 32'd0);

        $display("[TB] averaging 2,3,3,4");
        setSeq(15'h0003, 15'h0007, 15'h0007, 15'h000F);
        runConversion(1'b1, -1, lat);
        checkOutput("avg_latency", 32'(lat), 32'd21);
        checkOutput("avg_data", 32'(data_out), 32'd3);
        @(negedge clk);

        $display("[TB] backpressure in HOLD");
        applyStimulus(1'b0, 1'b0, 1'b0);
        setSeq(15'h0FFF, 15'h0FFF, 15'h0FFF, 15'h0FFF);
        runConversion(1'b1, -1, lat);
        checkOutput("bp_data", 32'(data_out), 32'd12);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(data_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(data_out), 32'd12);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(data_valid), 32'd0);
        checkOutput("bp_release_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_no_queue", 32'(busy), 32'd0);

        $display("[TB] continuous mode, full-scale code");
        applyStimulus(1'b0, 1'b1, 1'b1);
        setSeq(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF);
        runConversion(1'b1, -1, lat);
        checkOutput("cont1_latency", 32'(lat), 32'd21);
        checkOutput("cont1_data", 32'(data_out), 32'd15);
        runConversion(1'b0, -1, lat);
        checkOutput("cont2_latency", 32'(lat), 32'd21);
        checkOutput("cont2_data", 32'(data_out), 32'd15);
        runConversion(1'b0, 5, lat);
        checkOutput("cont3_latency", 32'(lat), 32'd21);
        checkOutput("cont3_data", 32'(data_out), 32'd15);
        @(negedge clk);
        checkOutput("cont_stop_idle", 32'(busy), 32'd0);

        $display("[TB] bubble on one sample");
        applyStimulus(1'b0, 1'b0, 1'b1);
        setSeq(15'h0007, 15'h0005, 15'h0007, 15'h0007);
        runConversion(1'b1, -1, lat);
        checkOutput("bubble_data", 32'(data_out), 32'd2);
        checkOutput("bubble_err_set", 32'(bubble_err), 32'd1);
        checkOutput("bubble_cnt_one", 32'(bubble_cnt), 32'd1);
        @(negedge clk);
        setSeq(15'h0001, 15'h0001, 15'h0001, 15'h0001);
        runConversion(1'b1, -1, lat);
        checkOutput("sticky_data", 32'(data_out), 32'd1);
        checkOutput("sticky_err", 32'(bubble_err), 32'd1);
        checkOutput("sticky_cnt", 32'(bubble_cnt), 32'd1);
        @(negedge clk);

        $display("[TB] reset during third capture");
        applyStimulus(1'b1, 1'b0, 1'b1);
        ith = 15'h007F;
        latches = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (comp_latch) latches++;
            if (latches == 3) break;
        end
        checkOutput("abort_reached", 32'(latches), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sample_en", 32'(sample_en), 32'd0);
        checkOutput("abort_latch", 32'(comp_latch), 32'd0);
        checkOutput("abort_valid", 32'(data_valid), 32'd0);
        checkOutput("abort_data", 32'(data_out), 32'd0);
        checkOutput("abort_bubble_err", 32'(bubble_err), 32'd0);
        checkOutput("abort_bubble_cnt", 32'(bubble_cnt), 32'd0);
        rst_n = 1'b1;
        setSeq(15'h001F, 15'h001F, 15'h001F, 15'h001F);
        runConversion(1'b1, -1, lat);
        checkOutput("recover_latency", 32'(lat), 32'd21);
        checkOutput("recover_data", 32'(data_out), 32'd5);
        @(negedge clk);
        checkOutput("recover_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adc_conv_ctrl.md
ADC_CONV_CTRL -- requirements
Module: adc_conv_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 3, comparator settle cycles per sample (legal 1..15).
REQ-002 Parameter AVG_LOG2, default 2, log2 of samples averaged per result (legal 0..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  request one conversion; sampled only in IDLE.
REQ-006 continuous  input  1  when 1, a new conversion starts automatically after each result handshake.
REQ-007 ith  input  15  thermometer code from the comparator bank; ith[0] is the lowest threshold.
REQ-008 sample_en  output  1  comparator enable/track; high during SETTLE.
REQ-009 comp_latch  output  1  comparator latch strobe; high during CAPTURE.
REQ-010 data_out  output  4  averaged conversion result.
REQ-011 data_valid  output  1  data_out valid; held until data_ready.
REQ-012 data_ready  input  1  consumer accepts data_out when data_valid and data_ready are both 1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 bubble_err  output  1  sticky; set when any captured code is not of the form 2^n-1.
REQ-015 bubble_cnt  output  8  count of bubbled samples; saturates at 255.

Function
REQ-016 FSM states: IDLE, SETTLE, CAPTURE, ACCUM, HOLD.
REQ-017 IDLE -> SETTLE when start=1; sample counter and accumulator clear on this transition.
REQ-018 SETTLE lasts exactly SETTLE_CYC cycles, then -> CAPTURE.
REQ-019 CAPTURE lasts 1 cycle; ith is registered at the end of that cycle; -> ACCUM.
REQ-020 ACCUM lasts 1 cycle: accumulator += popcount(registered ith) (0..15); bubble check is applied to the same value.
REQ-021 ACCUM -> SETTLE when fewer than 2^AVG_LOG2 samples are accumulated, otherwise -> HOLD.
REQ-022 Bubble-tolerant encoding: the result is the number of ones, never the X/default output of a pure case decoder.
REQ-023 Accumulator width is 4+AVG_LOG2 bits; it never overflows; data_out = accumulator >> AVG_LOG2 (truncation, no rounding).
REQ-024 data_out is registered on entry to HOLD and held stable while data_valid=1.
REQ-025 HOLD: data_valid=1; on handshake -> SETTLE (counter and accumulator cleared) if continuous=1, else -> IDLE.
REQ-026 Latency: data_valid rises (SETTLE_CYC+2)*2^AVG_LOG2+1 cycles after the edge that samples start=1 (defaults: 21).
REQ-027 start outside IDLE is ignored; no queuing.
REQ-028 Clearing continuous mid-conversion completes the current result and then returns to IDLE.
REQ-029 A bubble increments bubble_cnt by 1 per sample and sets bubble_err in the same ACCUM cycle; it does not abort the conversion.
REQ-030 bubble_err and bubble_cnt clear only on reset.

Reset
REQ-031 rst_n=0 at a clock edge: state=IDLE; data_out=0; data_valid=0; sample_en=0; comp_latch=0; busy=0; bubble_err=0; bubble_cnt=0; accumulator and counters=0.
REQ-032 Reset asserted mid-operation, including HOLD, discards the partial or pending result; no handshake is completed.

Structure
REQ-033 Shared package adc_pkg holds the FSM state enum, the code width (15), the result width (4) and the bubble counter width (8).
REQ-034 One sub-module, adc_therm_ones_count: combinational 15-bit popcount to 4 bits plus a valid-thermometer flag.

Verification
REQ-035 Defaults, ith=15'h007F held, single start, data_ready=1 -> data_valid at cycle 21, data_out=7, bubble_err=0.
REQ-036 AVG_LOG2=2, ith sequence 0x0003, 0x0007, 0x0007, 0x000F (counts 2, 3, 3, 4) -> data_out=3 (12>>2).
REQ-037 ith=15'h0005 (bubble) on one sample -> bubble_cnt=1, bubble_err=1, that sample contributes 2.
REQ-038 data_ready=0 for 10 cycles in HOLD -> data_valid and data_out stable; start pulses are ignored; one handshake -> IDLE.
REQ-039 continuous=1, ith=15'h7FFF -> back-to-back results of 15, with the next SETTLE starting the cycle after each handshake.
REQ-040 rst_n=0 during CAPTURE of the 3rd sample -> next cycle all outputs are at reset values; a new start gives full latency and a correct result.
